// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - launch side of a 2-phase toggle req/ack CDC for a multi-bit word
// Optional ack timeout with sticky error: define CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_xdata,
  output logic                  o_xreq,
  input  logic                  i_xack,
  output logic                  o_timeout
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK = 2'd1;
`ifdef CDC_TX_TIMEOUT_EN
  localparam logic [1:0] ST_ERROR    = 2'd2;
  localparam int         CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
`endif

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic                   ack_match;
  logic                   accept;

  logic [1:0]             state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   xreq_q, xreq_d;
  logic [DATA_WIDTH-1:0]  xdata_q, xdata_d;
`ifdef CDC_TX_TIMEOUT_EN
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
`endif

  // Resynchronise the far-side ack level; the first flop sees i_xack directly.
  // The chain clears on reset, so an ack held high across a local reset reaches
  // ack_s only after SYNC_STAGES edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], i_xack};
    end
  end

  assign ack_s     = ack_sync_q[SYNC_STAGES-1];
  assign ack_match = (ack_s == xreq_q);
  assign accept    = i_valid & ready_q & (state_q == ST_IDLE);

  // Next-state logic: capture and toggle on accept, then hold until the ack echo matches.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    xreq_d  = xreq_q;
    xdata_d = xdata_q;
`ifdef CDC_TX_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          xdata_d = i_data;
          xreq_d  = ~xreq_q;
          ready_d = 1'b0;
          state_d = ST_WAIT_ACK;
`ifdef CDC_TX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          ready_d = ack_match;
        end
      end
      ST_WAIT_ACK: begin
        ready_d = 1'b0;
        if (ack_match) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
`ifdef CDC_TX_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_ERROR;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
`ifdef CDC_TX_TIMEOUT_EN
      ST_ERROR: begin
        ready_d = 1'b0;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // Handshake state and the crossing data/req registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      xreq_q  <= 1'b0;
      xdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      xreq_q  <= xreq_d;
      xdata_q <= xdata_d;
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  // Wait counter and sticky timeout flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_ready = ready_q;
  assign o_xreq  = xreq_q;
  assign o_xdata = xdata_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb/tb_cdc_handshake_tx.sv - directed self-checking bench for cdc_handshake_tx
module tb_cdc_handshake_tx;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_xdata;
  logic        o_xreq;
  logic        i_xack;
  logic        o_timeout;

  int comparisons = 0;
  int fails       = 0;

  bit          echo_en;
  bit          rnd_en;
  int          fixed_delay;
  bit          rx_busy;
  int          rx_cnt;
  logic [31:0] rx_held;
  logic [31:0] rx_q[$];
  int          stab_err;
  int          toggles;
  logic        prev_xreq;

  always #5 i_clk = ~i_clk;

  cdc_handshake_tx #(
    .DATA_WIDTH    (32),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_xdata  (o_xdata),
    .o_xreq   (o_xreq),
    .i_xack   (i_xack),
    .o_timeout(o_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    comparisons++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and run the far-side receiver model.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (o_xreq !== prev_xreq) toggles++;
    prev_xreq = o_xreq;
    if (echo_en && (o_xreq !== i_xack)) begin
      if (!rx_busy) begin
        rx_busy = 1'b1;
        rx_held = o_xdata;
        rx_cnt  = rnd_en ? int'($urandom_range(0, 20)) : fixed_delay;
      end else if (o_xdata !== rx_held) begin
        stab_err++;
      end
      if (rx_cnt == 0) begin
        rx_q.push_back(o_xdata);
        i_xack  = o_xreq;
        rx_busy = 1'b0;
      end else begin
        rx_cnt--;
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (o_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(o_ready), 32'd1);
  endtask

  task automatic send(input logic [31:0] d);
    i_valid = 1'b1;
    i_data  = d;
    wait_ready("send_ready");
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    int n;
    i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_xack = 1'b0;
    echo_en = 1'b0; rnd_en = 1'b0; fixed_delay = 0; rx_busy = 1'b0; rx_cnt = 0;
    rx_held = '0; stab_err = 0; toggles = 0; prev_xreq = 1'b0;

    // Reset values, then ready on the first edge after release
    repeat (3) tick();
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_xreq", 32'(o_xreq), 32'd0);
    check("rst_xdata", o_xdata, 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    i_rst_n = 1'b1;
    tick();
    check("rel_ready", 32'(o_ready), 32'd1);
    check("rel_xreq", 32'(o_xreq), 32'd0);
    check("rel_xdata", o_xdata, 32'd0);

    // Single word with instant echo: ready back 3 edges after accept
    echo_en = 1'b1; fixed_delay = 0; rx_q.delete(); toggles = 0;
    i_valid = 1'b1; i_data = 32'hDEADBEEF;
    tick();
    i_valid = 1'b0;
    check("w1_xreq", 32'(o_xreq), 32'd1);
    check("w1_xdata", o_xdata, 32'hDEADBEEF);
    check("w1_ready_e0", 32'(o_ready), 32'd0);
    tick();
    check("w1_ready_e1", 32'(o_ready), 32'd0);
    tick();
    check("w1_ready_e2", 32'(o_ready), 32'd0);
    tick();
    check("w1_ready_e3", 32'(o_ready), 32'd1);
    check("w1_rx_count", 32'(rx_q.size()), 32'd1);
    check("w1_rx_data", rx_q[0], 32'hDEADBEEF);

    // Back-to-back words with random ack delay
    rnd_en = 1'b1; rx_q.delete(); toggles = 0; stab_err = 0;
    send(32'h1);
    send(32'h2);
    send(32'h3);
    wait_ready("b2b_done");
    check("b2b_toggles", 32'(toggles), 32'd3);
    check("b2b_rx_count", 32'(rx_q.size()), 32'd3);
    check("b2b_rx0", rx_q[0], 32'h1);
    check("b2b_rx1", rx_q[1], 32'h2);
    check("b2b_rx2", rx_q[2], 32'h3);
    check("b2b_stable", 32'(stab_err), 32'd0);
    check("b2b_xreq", 32'(o_xreq), 32'd0);

    // i_valid held with changing data during WAIT_ACK, including the ack-match edge
    rnd_en = 1'b0; fixed_delay = 10; toggles = 0;
    i_valid = 1'b1; i_data = 32'hA5A50001;
    tick();
    check("hold_accept", o_xdata, 32'hA5A50001);
    n = 0;
    while (o_ready !== 1'b1 && n < 60) begin
      i_data = $urandom;
      tick();
      check("hold_xdata", o_xdata, 32'hA5A50001);
      n++;
    end
    check("hold_ready", 32'(o_ready), 32'd1);
    check("hold_toggles", 32'(toggles), 32'd1);
    i_valid = 1'b0;
    tick();
    check("hold_no_extra", 32'(toggles), 32'd1);
    check("hold_xdata_end", o_xdata, 32'hA5A50001);

    // Far ack stuck at 1 through a local reset
    echo_en = 1'b0;
    i_rst_n = 1'b0;
    tick();
    tick();
    check("midrst_xreq", 32'(o_xreq), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd0);
    i_rst_n = 1'b1; rx_busy = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      check("stuck_ready", 32'(o_ready), 32'd0);
      tick();
    end
    i_xack = 1'b0;
    tick();
    check("drop_ready_e1", 32'(o_ready), 32'd0);
    tick();
    check("drop_ready_e2", 32'(o_ready), 32'd0);
    tick();
    check("drop_ready_e3", 32'(o_ready), 32'd1);

    // Ack never returned
    i_valid = 1'b1; i_data = 32'h55;
    tick();
    i_valid = 1'b0;
    check("to_xreq", 32'(o_xreq), 32'd1);
`ifdef CDC_TX_TIMEOUT_EN
    repeat (15) tick();
    check("to_before", 32'(o_timeout), 32'd0);
    tick();
    check("to_flag", 32'(o_timeout), 32'd1);
    check("to_ready", 32'(o_ready), 32'd0);
    i_xack = 1'b1;
    repeat (6) tick();
    check("to_late_ready", 32'(o_ready), 32'd0);
    check("to_late_flag", 32'(o_timeout), 32'd1);
`else
    repeat (40) tick();
    check("to_flag", 32'(o_timeout), 32'd0);
    check("to_ready", 32'(o_ready), 32'd0);
    i_xack = 1'b1;
    repeat (6) tick();
    check("to_late_ready", 32'(o_ready), 32'd1);
    check("to_late_flag", 32'(o_timeout), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparisons, fails);
    $finish;
  end

endmodule
